int_controller: RTL

Interrupt controller feeding the multicycle CPU control unit. It collects external interrupt request lines, masks and prioritises them, and raises `int_sig`. When the control unit acknowledges with `int_save_pc`, it saves the return PC (EPC), latches the cause, and presents the handler vector address for the PC mux. It also supplies EPC back to the PC mux for return-from-exception.

---
 rtl/int_controller.sv | 132 +++++++++++++
 1 files changed

// File: rtl/int_controller.sv
// int_controller: interrupt controller for the multicycle CPU control unit.
// Collects request lines into a pending register, masks and prioritises them
// (lowest index wins), raises int_sig, and on acknowledge saves the return PC,
// the cause index and the handler vector address.
//
// Build option: define INT_CTRL_LEVEL_EN for level-sensitive request capture;
// left undefined, requests are captured on rising edges of irq_in.
//
// Handshake: int_sig is a registered-only request (state and pending & mask);
// the control unit takes it by pulsing int_save_pc while int_sig is high. A
// pulse of int_save_pc while int_sig is low does nothing. The block then stays
// in SERVICE, refusing further acks, until rfe returns it to IDLE.
module int_controller #(
  parameter int          N_IRQ      = 4,
  parameter int          CAUSE_W    = 2,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_IRQ-1:0]   irq_in,
  input  logic               mask_we,
  input  logic [N_IRQ-1:0]   mask_wdata,
  input  logic               int_save_pc,
  input  logic               rfe,
  input  logic [31:0]        pc_in,
  output logic               int_sig,
  output logic [31:0]        int_vector,
  output logic [31:0]        epc,
  output logic [CAUSE_W-1:0] int_cause,
  output logic [N_IRQ-1:0]   pending
);

  typedef enum logic {
    IDLE    = 1'b0,
    SERVICE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [N_IRQ-1:0]   irq_prev_q, irq_prev_d;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   mask_q, mask_d;
  logic [31:0]        epc_q, epc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [31:0]        vector_q, vector_d;

  logic [N_IRQ-1:0]   set_ev;
  logic [N_IRQ-1:0]   clr_ev;
  logic [N_IRQ-1:0]   req;
  logic [CAUSE_W-1:0] winner;
  logic               ack;

  // Request set events: level or rising-edge depending on build option
  always_comb begin
`ifdef INT_CTRL_LEVEL_EN
    set_ev = irq_in;
`else
    set_ev = irq_in & ~irq_prev_q;
`endif
  end

  // Lowest-index enabled pending line wins; uses the mask currently held
  always_comb begin
    req    = pending_q & mask_q;
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) winner = CAUSE_W'(i);
    end
  end

  assign int_sig = (state_q == IDLE) && (|req);
  assign ack     = int_save_pc && int_sig;

  // FSM next state plus all register next values
  always_comb begin
    state_d    = state_q;
    irq_prev_d = irq_in;
    mask_d     = mask_q;
    epc_d      = epc_q;
    cause_d    = cause_q;
    vector_d   = vector_q;
    clr_ev     = '0;

    if (mask_we) mask_d = mask_wdata;

    case (state_q)
      IDLE: begin
        if (ack) begin
          epc_d          = pc_in;
          cause_d        = winner;
          vector_d       = VEC_BASE + (32'(winner) * VEC_STRIDE);
          clr_ev[winner] = 1'b1;
          state_d        = SERVICE;
        end
      end
      SERVICE: begin
        if (rfe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A set in the same cycle as its clear keeps the line pending
    pending_d = (pending_q & ~clr_ev) | set_ev;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '1;
      epc_q      <= '0;
      cause_q    <= '0;
      vector_q   <= VEC_BASE;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      epc_q      <= epc_d;
      cause_q    <= cause_d;
      vector_q   <= vector_d;
    end
  end

  assign pending    = pending_q;
  assign epc        = epc_q;
  assign int_cause  = cause_q;
  assign int_vector = vector_q;

endmodule
